// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: builds mip from the CLINT/external levels, gates it with
// mie/mstatus.MIE and sequences trap entry (mepc, mcause, mstatus, redirect) and mret return.
module irq_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  timer_irq_i,
    input  logic                  software_irq_i,
    input  logic                  external_irq_i,
    input  logic [DATA_WIDTH-1:0] mstatus_i,
    input  logic [DATA_WIDTH-1:0] mie_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    input  logic                  commit_valid_i,
    input  logic [DATA_WIDTH-1:0] commit_pc_i,
    input  logic                  stall_i,
    input  logic                  mret_i,
    output logic [DATA_WIDTH-1:0] mip_o,
    output logic                  flush_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  busy_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] T_MEPC    = 3'd1;
    localparam logic [2:0] T_MCAUSE  = 3'd2;
    localparam logic [2:0] T_MSTATUS = 3'd3;
    localparam logic [2:0] T_JUMP    = 3'd4;
    localparam logic [2:0] R_RET     = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [3:0]            cause_q, cause_d;
    logic [DATA_WIDTH-1:0] mip_q, mip_d;

    logic                  flush_q, flush_d;
    logic                  we_q, we_d;
    logic [11:0]           waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] rpc_q, rpc_d;

    logic [DATA_WIDTH-1:0] pend;
    logic                  take;
    logic                  do_mret;
    logic [3:0]            sel_cause;
    logic [DATA_WIDTH-1:0] trap_mstatus;
    logic [DATA_WIDTH-1:0] ret_mstatus;
    logic [DATA_WIDTH-1:0] mcause_val;
    logic [DATA_WIDTH-1:0] tvec_base;
    logic [DATA_WIDTH-1:0] tvec_off;

    always_comb begin
        mip_d     = '0;
        mip_d[3]  = software_irq_i;
        mip_d[7]  = timer_irq_i;
        mip_d[11] = external_irq_i;
    end

    assign pend    = mip_q & mie_i;
    assign take    = (state_q == IDLE) & mstatus_i[3] & (pend[11] | pend[3] | pend[7]) &
                     commit_valid_i & ~stall_i;
    assign do_mret = (state_q == IDLE) & mret_i & commit_valid_i & ~stall_i & ~take;

    // Fixed priority: external > software > timer.
    assign sel_cause = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = T_MEPC;
                    epc_d   = commit_pc_i;
                    cause_d = sel_cause;
                end else if (do_mret) begin
                    state_d = R_RET;
                end
            end
            T_MEPC:    state_d = T_MCAUSE;
            T_MCAUSE:  state_d = T_MSTATUS;
            T_MSTATUS: state_d = T_JUMP;
            T_JUMP:    state_d = IDLE;
            R_RET:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;

        ret_mstatus         = mstatus_i;
        ret_mstatus[3]      = mstatus_i[7];
        ret_mstatus[7]      = 1'b1;
        ret_mstatus[12:11]  = 2'b11;

        mcause_val               = '0;
        mcause_val[DATA_WIDTH-1] = 1'b1;
        mcause_val[3:0]          = cause_d;

        tvec_base = {mtvec_i[DATA_WIDTH-1:2], 2'b00};
        tvec_off  = (VECTORED_EN && (mtvec_i[1:0] == 2'b01)) ?
                    DATA_WIDTH'({cause_d, 2'b00}) : '0;
    end

    // Outputs are registered by decoding the state being entered.
    always_comb begin
        flush_d = 1'b0;
        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        rv_d    = 1'b0;
        rpc_d   = '0;
        case (state_d)
            T_MEPC: begin
                flush_d = 1'b1;
                we_d    = 1'b1;
                waddr_d = CSR_MEPC;
                wdata_d = epc_d;
            end
            T_MCAUSE: begin
                we_d    = 1'b1;
                waddr_d = CSR_MCAUSE;
                wdata_d = mcause_val;
            end
            T_MSTATUS: begin
                we_d    = 1'b1;
                waddr_d = CSR_MSTATUS;
                wdata_d = trap_mstatus;
            end
            T_JUMP: begin
                rv_d  = 1'b1;
                rpc_d = tvec_base + tvec_off;
            end
            R_RET: begin
                flush_d = 1'b1;
                we_d    = 1'b1;
                waddr_d = CSR_MSTATUS;
                wdata_d = ret_mstatus;
                rv_d    = 1'b1;
                rpc_d   = mepc_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mip_q   <= '0;
            flush_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mip_q   <= mip_d;
            flush_q <= flush_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
        end
    end

    assign mip_o            = mip_q;
    assign flush_o          = flush_q;
    assign csr_we_o         = we_q;
    assign csr_waddr_o      = waddr_q;
    assign csr_wdata_o      = wdata_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rpc_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traps checked against a rule-level reference model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_irq, software_irq, external_irq;
    logic [31:0] mstatus, mie, mtvec, mepc, commit_pc;
    logic        commit_valid, stall, mret;
    logic [31:0] mip;
    logic        flush, csr_we, redirect_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.DATA_WIDTH(32), .VECTORED_EN(1'b1)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .timer_irq_i      (timer_irq),
        .software_irq_i   (software_irq),
        .external_irq_i   (external_irq),
        .mstatus_i        (mstatus),
        .mie_i            (mie),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .commit_valid_i   (commit_valid),
        .commit_pc_i      (commit_pc),
        .stall_i          (stall),
        .mret_i           (mret),
        .mip_o            (mip),
        .flush_o          (flush),
        .csr_we_o         (csr_we),
        .csr_waddr_o      (csr_waddr),
        .csr_wdata_o      (csr_wdata),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy)
    );

    typedef struct {
        logic        t, s, e;
        logic [31:0] mie, ms, mtvec, pc, mepc;
        logic        cv, stall, mret;
        int          kind;        // 0 nothing, 1 trap, 2 mret
        logic [31:0] exp_mip, exp_mcause, exp_ms, exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {flush, we, addr, data, redirect_valid, redirect_pc, busy}
    function automatic logic [79:0] beat(logic f, logic we, logic [11:0] a, logic [31:0] d,
                                         logic rv, logic [31:0] rpc, logic b);
        return {f, we, a, d, rv, rpc, b};
    endfunction

    task automatic check_beat(string name, logic [79:0] exp);
        logic [79:0] act;
        act = {flush, csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, busy};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (flush,we,addr,data,rv,rpc,busy)", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called in the cycle where the mepc beat is visible; walks the whole trap entry.
    task automatic check_trap(string name, logic [31:0] pc, logic [31:0] mc, logic [31:0] ms,
                              logic [31:0] rpc, logic drop);
        commit_valid = 1'b0;
        mret         = 1'b0;
        stall        = 1'b0;
        check_beat({name, ".mepc"}, beat(1, 1, 12'h341, pc, 0, 0, 1));
        step();
        if (drop) timer_irq = 1'b0;
        check_beat({name, ".mcause"}, beat(0, 1, 12'h342, mc, 0, 0, 1));
        step();
        check_beat({name, ".mstatus"}, beat(0, 1, 12'h300, ms, 0, 0, 1));
        step();
        check_beat({name, ".jump"}, beat(0, 0, 0, 0, 1, rpc, 1));
        step();
        check_beat({name, ".idle"}, '0);
    endtask

    // Reference model: rules stated on architectural fields, not on FSM internals.
    function automatic logic [31:0] m_mip(logic t, logic s, logic e);
        return (32'(e) << 11) | (32'(t) << 7) | (32'(s) << 3);
    endfunction

    function automatic int m_cause(logic [31:0] enabled);
        int prio[3] = '{11, 3, 7};
        foreach (prio[i]) if (enabled[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic logic [31:0] m_trap_ms(logic [31:0] ms);
        return (ms & ~32'h0000_1888) | 32'h0000_1800 | (32'(ms[3]) << 7);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] tv, int cause);
        logic [31:0] base;
        base = tv & ~32'h3;
        if (tv[1:0] == 2'b01) return base + 32'(4 * cause);
        return base;
    endfunction

    task automatic run_vec(int idx, vec_t v);
        string n;
        n = $sformatf("vec%0d", idx);
        timer_irq = v.t; software_irq = v.s; external_irq = v.e;
        mie = v.mie; mstatus = v.ms; mtvec = v.mtvec; mepc = v.mepc;
        commit_valid = 1'b0; stall = 1'b0; mret = 1'b0; commit_pc = v.pc;
        step();
        check32({n, ".mip"}, mip, v.exp_mip);
        commit_valid = v.cv; stall = v.stall; mret = v.mret;
        step();
        if (v.kind == 1) begin
            check_trap(n, v.pc, v.exp_mcause, v.exp_ms, v.exp_pc, 1'b0);
        end else if (v.kind == 2) begin
            commit_valid = 1'b0; mret = 1'b0;
            check_beat({n, ".ret"}, beat(1, 1, 12'h300, v.exp_ms, 1, v.exp_pc, 1));
            step();
            check_beat({n, ".idle"}, '0);
        end else begin
            check_beat({n, ".none"}, '0);
            step();
            commit_valid = 1'b0; stall = 1'b0;
            check_beat({n, ".none2"}, '0);
        end
    endtask

    initial begin
        // t s e  mie        ms           mtvec        pc           mepc         cv st mr kind
        //        exp_mip    exp_mcause   exp_ms       exp_pc
        vecs[0]  = '{1, 0, 0, 32'h080, 32'h8, 32'h8000_0000, 32'h8000_0100, 0, 1, 0, 0, 1,
                     32'h080, 32'h8000_0007, 32'h1880, 32'h8000_0000};
        vecs[1]  = '{1, 1, 1, 32'h888, 32'h8, 32'h8000_0001, 32'h8000_0200, 0, 1, 0, 0, 1,
                     32'h888, 32'h8000_000B, 32'h1880, 32'h8000_002C};
        vecs[2]  = '{1, 0, 0, 32'h080, 32'h0, 32'h8000_0000, 32'h8000_0100, 0, 1, 0, 0, 0,
                     32'h080, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 32'h000, 32'h8, 32'h8000_0000, 32'h8000_0100, 0, 1, 0, 0, 0,
                     32'h080, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 32'h080, 32'h8, 32'h8000_0000, 32'h8000_0100, 0, 1, 1, 0, 0,
                     32'h080, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 32'h080, 32'h8, 32'h8000_0000, 32'h8000_0100, 0, 0, 0, 0, 0,
                     32'h080, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 32'h888, 32'h1880, 32'h8000_0000, 32'h8000_0104, 32'h8000_0104,
                     1, 0, 1, 2, 32'h000, 0, 32'h1888, 32'h8000_0104};
        vecs[7]  = '{1, 0, 0, 32'h080, 32'h88, 32'h8000_0000, 32'h8000_0300, 32'h8000_0104,
                     1, 0, 1, 1, 32'h080, 32'h8000_0007, 32'h1880, 32'h8000_0000};
        vecs[8]  = '{0, 1, 0, 32'h008, 32'h8, 32'h8000_0101, 32'h8000_0400, 0, 1, 0, 0, 1,
                     32'h008, 32'h8000_0003, 32'h1880, 32'h8000_010C};
        vecs[9]  = '{1, 0, 1, 32'h080, 32'h8, 32'h8000_0001, 32'h8000_0500, 0, 1, 0, 0, 1,
                     32'h880, 32'h8000_0007, 32'h1880, 32'h8000_001C};
        vecs[10] = '{0, 0, 1, 32'h800, 32'h8, 32'h8000_0002, 32'h8000_0600, 0, 1, 0, 0, 1,
                     32'h800, 32'h8000_000B, 32'h1880, 32'h8000_0000};
        vecs[11] = '{1, 0, 0, 32'h080, 32'hAA00_0008, 32'hFFFF_FFFD, 32'h8000_0700, 0, 1, 0, 0,
                     1, 32'h080, 32'h8000_0007, 32'hAA00_1880, 32'h0000_0018};

        rst = 1'b1;
        timer_irq = 1'b1; software_irq = 1'b1; external_irq = 1'b1;
        mstatus = 32'h8; mie = 32'h888; mtvec = '0; mepc = '0; commit_pc = '0;
        commit_valid = 1'b1; stall = 1'b0; mret = 1'b0;
        step();
        step();
        check_beat("reset.outputs", '0);
        check32("reset.mip", mip, 32'h0);
        commit_valid = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Stall holds off the take; releasing it takes on the next edge.
        timer_irq = 1; software_irq = 0; external_irq = 0;
        mie = 32'h80; mstatus = 32'h8; mtvec = 32'h8000_0000; commit_pc = 32'h8000_0800;
        step();
        commit_valid = 1; stall = 1;
        step();
        step();
        check_beat("stall.held", '0);
        stall = 0;
        step();
        check_trap("stall.release", 32'h8000_0800, 32'h8000_0007, 32'h1880, 32'h8000_0000, 1);
        step();
        check32("drop.mip", mip, 32'h0);

        // Reset during T_MSTATUS abandons the sequence.
        timer_irq = 1; commit_pc = 32'h8000_0900;
        step();
        commit_valid = 1;
        step();
        commit_valid = 0;
        check_beat("rstmid.mepc", beat(1, 1, 12'h341, 32'h8000_0900, 0, 0, 1));
        step();
        step();
        check_beat("rstmid.mstatus", beat(0, 1, 12'h300, 32'h1880, 0, 0, 1));
        rst = 1;
        #1;
        check_beat("rstmid.async", '0);
        check32("rstmid.mip", mip, 32'h0);
        timer_irq = 0;
        step();
        rst = 0;
        step();
        check_beat("rstmid.after1", '0);
        step();
        check_beat("rstmid.after2", '0);

        // Back-to-back: pending irq retaken in the first IDLE cycle after T_JUMP.
        timer_irq = 1; commit_pc = 32'h8000_0A00;
        step();
        commit_valid = 1;
        step();
        commit_pc = 32'h8000_0B00;
        check_beat("b2b.mepc", beat(1, 1, 12'h341, 32'h8000_0A00, 0, 0, 1));
        step();
        check_beat("b2b.mcause", beat(0, 1, 12'h342, 32'h8000_0007, 0, 0, 1));
        step();
        check_beat("b2b.mstatus", beat(0, 1, 12'h300, 32'h1880, 0, 0, 1));
        step();
        check_beat("b2b.jump", beat(0, 0, 0, 0, 1, 32'h8000_0000, 1));
        step();
        check_beat("b2b.idle", '0);
        step();
        check_trap("b2b.second", 32'h8000_0B00, 32'h8000_0007, 32'h1880, 32'h8000_0000, 0);
        timer_irq = 0;

        // Randomized traps against the reference model.
        for (int it = 0; it < 150; it++) begin
            logic        t, s, e, cv, st, exp_take;
            logic [31:0] ms, ie, tv, pc, em;
            int          c;
            t = 1'($urandom); s = 1'($urandom); e = 1'($urandom);
            ms = $urandom; ie = $urandom;
            tv = ($urandom & ~32'h3) | 32'($urandom_range(0, 3));
            pc = $urandom & ~32'h3;
            cv = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            timer_irq = t; software_irq = s; external_irq = e;
            mstatus = ms; mie = ie; mtvec = tv; commit_pc = pc;
            commit_valid = 0; stall = 0; mret = 0;
            step();
            em = m_mip(t, s, e);
            check32($sformatf("rnd%0d.mip", it), mip, em);
            c = m_cause(em & ie);
            exp_take = ms[3] && (c >= 0) && cv && !st;
            commit_valid = cv; stall = st;
            step();
            if (exp_take) begin
                check_trap($sformatf("rnd%0d", it), pc, 32'h8000_0000 | 32'(c), m_trap_ms(ms),
                           m_target(tv, c), 1'b0);
            end else begin
                commit_valid = 0; stall = 0;
                check_beat($sformatf("rnd%0d.none", it), '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
